// File: rtl/module_ifetch.sv
// Instruction-fetch stage: owns the fetch PC, runs the instruction-memory
// request/acknowledge handshake, squashes in-flight fetches on redirect and
// holds one fetched instruction for decode.
module module_ifetch #(
    parameter int WORD_SIZE    = 32,
    parameter int RESET_VECTOR = 0,
    parameter int PC_STEP      = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    output logic                 imem_req,
    output logic [WORD_SIZE-1:0] imem_addr,
    input  logic                 imem_ack,
    input  logic [WORD_SIZE-1:0] imem_rdata,
    input  logic                 stall,
    input  logic                 branch_valid,
    input  logic [WORD_SIZE-1:0] branch_target,
    output logic                 if_valid,
    output logic [WORD_SIZE-1:0] if_instr,
    output logic [WORD_SIZE-1:0] if_pc
);

    localparam logic [WORD_SIZE-1:0] RST_PC  = WORD_SIZE'(RESET_VECTOR);
    localparam logic [WORD_SIZE-1:0] STEP    = WORD_SIZE'(PC_STEP);
    localparam logic [WORD_SIZE-1:0] ZERO_W  = {WORD_SIZE{1'b0}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DRAIN = 2'd2,
        ST_FULL  = 2'd3
    } state_e;

    // Clears the two byte-offset bits so every redirect lands on a word.
    function automatic logic [WORD_SIZE-1:0] word_align(input logic [WORD_SIZE-1:0] a);
        word_align = a & {{(WORD_SIZE-2){1'b1}}, 2'b00};
    endfunction

    state_e                 state_q, state_d;
    logic [WORD_SIZE-1:0]   pc_q, pc_d;
    logic [WORD_SIZE-1:0]   pend_q, pend_d;
    logic                   req_q, req_d;
    logic [WORD_SIZE-1:0]   addr_q, addr_d;
    logic                   valid_q, valid_d;
    logic [WORD_SIZE-1:0]   instr_q, instr_d;
    logic [WORD_SIZE-1:0]   ifpc_q, ifpc_d;
    logic [WORD_SIZE-1:0]   tgt_s;

    assign tgt_s = word_align(branch_target);

    // Next-state, PC, pending-redirect and output-register computation.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        pend_d  = pend_q;
        valid_d = valid_q;
        instr_d = instr_q;
        ifpc_d  = ifpc_q;
        case (state_q)
            ST_IDLE: begin
                // A stray ack while idle has no request to belong to.
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (imem_ack) begin
                    if (branch_valid) begin
                        // Data for the old path is dropped; re-request at target.
                        pc_d    = tgt_s;
                        state_d = ST_FETCH;
                    end else begin
                        instr_d = imem_rdata;
                        ifpc_d  = pc_q;
                        valid_d = 1'b1;
                        pc_d    = pc_q + STEP;
                        state_d = ST_FULL;
                    end
                end else if (branch_valid) begin
                    // Request cannot be withdrawn; remember target and wait it out.
                    pend_d  = tgt_s;
                    state_d = ST_DRAIN;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_DRAIN: begin
                if (imem_ack) begin
                    // Latest redirect wins, including one in the ack cycle.
                    pc_d    = branch_valid ? tgt_s : pend_q;
                    state_d = ST_FETCH;
                end else if (branch_valid) begin
                    pend_d  = tgt_s;
                    state_d = ST_DRAIN;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            ST_FULL: begin
                if (branch_valid) begin
                    // Held instruction is on the wrong path; branch beats stall.
                    valid_d = 1'b0;
                    pc_d    = tgt_s;
                    state_d = ST_FETCH;
                end else if (!stall) begin
                    valid_d = 1'b0;
                    state_d = ST_FETCH;
                end else begin
                    state_d = ST_FULL;
                end
            end
            default: begin
                state_d = ST_IDLE;
                valid_d = 1'b0;
            end
        endcase
        // Request flops follow the next state so the port is a clean register;
        // the address is frozen while draining a squashed request.
        req_d = (state_d == ST_FETCH) || (state_d == ST_DRAIN);
        if (state_d == ST_DRAIN) begin
            addr_d = addr_q;
        end else begin
            addr_d = pc_d;
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            pc_q    <= RST_PC;
            pend_q  <= ZERO_W;
            req_q   <= 1'b0;
            addr_q  <= RST_PC;
            valid_q <= 1'b0;
            instr_q <= ZERO_W;
            ifpc_q  <= ZERO_W;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            pend_q  <= pend_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
            valid_q <= valid_d;
            instr_q <= instr_d;
            ifpc_q  <= ifpc_d;
        end
    end

    assign imem_req  = req_q;
    assign imem_addr = addr_q;
    assign if_valid  = valid_q;
    assign if_instr  = instr_q;
    assign if_pc     = ifpc_q;

endmodule

// File: tb/tb_module_ifetch.sv
// Directed testbench for module_ifetch: sequential fetch, wait states, stall,
// redirect while a request is outstanding, PC wrap and mid-request reset.
module tb_module_ifetch;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        branch_valid;
    logic [31:0] branch_target;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    module_ifetch #(.WORD_SIZE(32), .RESET_VECTOR(0), .PC_STEP(4)) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .stall(stall), .branch_valid(branch_valid), .branch_target(branch_target),
        .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc)
    );

    // Memory returns a recognisable function of the requested address.
    assign imem_rdata = imem_addr ^ 32'hA5A5A5A5;

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_cnt++;
        if (obs === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_fetch(input string tag, input logic [31:0] a);
        check({tag, "_req"},   {31'd0, imem_req}, 32'd1);
        check({tag, "_addr"},  imem_addr, a);
        check({tag, "_valid"}, {31'd0, if_valid}, 32'd0);
    endtask

    task automatic exp_full(input string tag, input logic [31:0] pc, input logic [31:0] ins);
        check({tag, "_req"},   {31'd0, imem_req}, 32'd0);
        check({tag, "_valid"}, {31'd0, if_valid}, 32'd1);
        check({tag, "_pc"},    if_pc, pc);
        check({tag, "_instr"}, if_instr, ins);
    endtask

    task automatic exp_idle(input string tag);
        check({tag, "_req"},   {31'd0, imem_req}, 32'd0);
        check({tag, "_addr"},  imem_addr, 32'h0);
        check({tag, "_valid"}, {31'd0, if_valid}, 32'd0);
        check({tag, "_pc"},    if_pc, 32'h0);
        check({tag, "_instr"}, if_instr, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; imem_ack = 1'b0; stall = 1'b0;
        branch_valid = 1'b0; branch_target = 32'h0;
        tick(); tick();
        exp_idle("reset");

        // Sequential fetch with zero-wait memory.
        reset = 1'b0; imem_ack = 1'b1;
        tick(); exp_fetch("f0", 32'h0);
        tick(); exp_full("full0", 32'h0, 32'hA5A5A5A5);

        // Wait states at 0x4: ack only in the fourth request cycle.
        imem_ack = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) begin
            exp_fetch("wait4", 32'h4);
            tick();
        end
        exp_fetch("wait4_last", 32'h4);
        imem_ack = 1'b1;
        tick(); exp_full("full4", 32'h4, 32'hA5A5A5A1);

        // Fetch 0x8 then stall four cycles in FULL (ack held high, ignored).
        tick(); exp_fetch("f8", 32'h8);
        stall = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) begin
            exp_full("stall8", 32'h8, 32'hA5A5A5AD);
            tick();
        end
        exp_full("stall8_last", 32'h8, 32'hA5A5A5AD);
        stall = 1'b0;
        tick(); exp_fetch("fC", 32'hC);
        tick(); exp_full("fullC", 32'hC, 32'hA5A5A5A9);

        // Redirect to 0x100 while request at 0x10 is outstanding.
        imem_ack = 1'b0;
        tick(); exp_fetch("f10", 32'h10);
        branch_valid = 1'b1; branch_target = 32'h100;
        tick(); exp_fetch("drain10a", 32'h10);
        branch_valid = 1'b0;
        tick(); exp_fetch("drain10b", 32'h10);
        imem_ack = 1'b1;
        tick(); exp_fetch("f100", 32'h100);

        // Two redirects during a drain: the later one (0x200) wins.
        imem_ack = 1'b0; branch_valid = 1'b1; branch_target = 32'h300;
        tick(); exp_fetch("drain100a", 32'h100);
        branch_target = 32'h200;
        tick(); exp_fetch("drain100b", 32'h100);
        branch_valid = 1'b0; imem_ack = 1'b1;
        tick(); exp_fetch("f200", 32'h200);

        // Redirect arriving in the drain's ack cycle is used directly.
        imem_ack = 1'b0; branch_valid = 1'b1; branch_target = 32'h20;
        tick(); exp_fetch("drain200", 32'h200);
        imem_ack = 1'b1; branch_target = 32'h80;
        tick(); exp_fetch("f80", 32'h80);
        branch_valid = 1'b0;
        tick(); exp_full("full80", 32'h80, 32'hA5A5A525);

        // Branch beats stall in FULL.
        stall = 1'b1; branch_valid = 1'b1; branch_target = 32'h40; imem_ack = 1'b0;
        tick(); exp_fetch("f40", 32'h40);
        // Branch with same-cycle ack in FETCH; low target bits are dropped.
        stall = 1'b0; imem_ack = 1'b1; branch_target = 32'h43;
        tick(); exp_fetch("f40_again", 32'h40);
        branch_valid = 1'b0;
        tick(); exp_full("full40", 32'h40, 32'hA5A5A5E5);

        // PC wrap at the top of the address space.
        branch_valid = 1'b1; branch_target = 32'hFFFFFFFC; imem_ack = 1'b0;
        tick(); exp_fetch("fTop", 32'hFFFFFFFC);
        branch_valid = 1'b0; imem_ack = 1'b1;
        tick(); exp_full("fullTop", 32'hFFFFFFFC, 32'h5A5A5A59);
        imem_ack = 1'b0;
        tick(); exp_fetch("fWrap", 32'h0);
        tick(); exp_fetch("fWrapWait", 32'h0);

        // Reset mid-request, then a late ack while idle is ignored.
        reset = 1'b1;
        tick(); exp_idle("midreset");
        reset = 1'b0; imem_ack = 1'b1;
        tick(); exp_fetch("restart", 32'h0);
        tick(); exp_full("restartFull", 32'h0, 32'hA5A5A5A5);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/module_ifetch.md
Name: module_ifetch

Overview:
- Instruction-fetch stage directly downstream of the program counter; owns the fetch PC, drives the instruction-memory request/acknowledge handshake, and holds one fetched instruction in an output register for the decode stage.
- Supports decode backpressure (stall) and branch/jump redirect, including a redirect that arrives while a memory request is outstanding.

Parameters:
WORD_SIZE, 32, data/address width in bits
RESET_VECTOR, 0, PC value loaded on reset; must be word-aligned
PC_STEP, 4, increment applied to PC after each accepted fetch

Ports:
clk  in  1  clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
imem_req  out  1  instruction memory request
imem_addr  out  WORD_SIZE  fetch address; stable while imem_req high
imem_ack  in  1  memory completes request this cycle; ignored when imem_req=0
imem_rdata  in  WORD_SIZE  instruction word; valid only with imem_ack
stall  in  1  decode cannot accept the held instruction this cycle
branch_valid  in  1  redirect fetch to branch_target
branch_target  in  WORD_SIZE  redirect address; bits [1:0] forced to 0
if_valid  out  1  if_instr/if_pc hold a valid instruction
if_instr  out  WORD_SIZE  fetched instruction
if_pc  out  WORD_SIZE  address of if_instr

Behaviour:
- Reset, synchronous and active-high, has priority over every other input. After reset: state=IDLE, pc=RESET_VECTOR, imem_req=0, imem_addr=RESET_VECTOR, if_valid=0, if_instr=0, if_pc=0, pending target=0.
- imem_req=1 exactly in states FETCH and DRAIN. imem_addr=pc in FETCH and the latched old address in DRAIN. Once asserted, req and addr hold until the ack cycle.
- Handshake completes in the cycle where imem_req=1 and imem_ack=1. The memory may ack in the first request cycle, giving 1-cycle fetch latency, or after any number of wait cycles.
- IDLE: imem_req=0; go to FETCH next cycle unconditionally. A late ack here is ignored.
- FETCH:
  - ack and no branch: if_instr<=imem_rdata, if_pc<=pc, if_valid<=1, pc<=pc+PC_STEP, go to FULL.
  - ack and branch: discard the data, keep if_valid=0, pc<=target, stay in FETCH. imem_req stays high and the next cycle presents the new address.
  - branch without ack: pending<=target, go to DRAIN. Request and address are held.
  - neither: stay in FETCH.
- DRAIN (squash the outstanding request):
  - on ack: discard the data, pc<=pending, go to FETCH.
  - a branch while in DRAIN overwrites pending, so the latest redirect wins. A branch in the ack cycle is used directly as the new pc.
- FULL: imem_req=0, if_valid=1.
  - branch: if_valid<=0, pc<=target, go to FETCH. Branch has priority over stall.
  - else !stall: instruction consumed this cycle; if_valid<=0, go to FETCH.
  - else stall: hold if_instr, if_pc, if_valid unchanged.
- Throughput is at most one instruction per 2 cycles with zero-wait memory: FETCH(ack) -> FULL(consume) -> FETCH.
- stall is ignored outside FULL. No new request is issued while the output register is occupied.
- PC arithmetic is modulo 2^WORD_SIZE: 0xFFFFFFFC + 4 = 0x00000000 with no flag.
- Reset mid-request (FETCH or DRAIN): imem_req=0 on the next cycle, and any pending redirect is dropped.

Test Plan:
1. Reset, RESET_VECTOR=0, memory acks every request with rdata=addr^0xA5A5A5A5, stall=0 -> imem_addr sequence 0x0,0x4,0x8. if_valid pulses every 2nd cycle with if_pc 0x0,0x4,0x8 and if_instr 0xA5A5A5A5,0xA5A5A5A1,0xA5A5A5AD.
2. Memory wait states: ack 3 cycles after req at 0x4 -> imem_req and imem_addr=0x4 are stable for all 3 cycles, and if_valid stays 0 until the cycle after ack.
3. Stall 4 cycles while FULL with if_pc=0x8 -> if_instr and if_pc are unchanged and imem_req=0 throughout. After stall drops, the next request goes to 0xC.
4. Branch to 0x100 during an outstanding request at 0x10 with ack 2 cycles later -> data for 0x10 is never presented (if_valid=0), and the next request is 0x100. A second branch to 0x200 during DRAIN sends the next request to 0x200.
5. Branch to 0x40 with stall=1 while FULL -> if_valid drops the next cycle, and the next request is 0x40. A branch with a same-cycle ack in FETCH presents 0x40 the next cycle.
6. Branch target 0xFFFFFFFC, then continue -> next fetch 0x00000000. Reset asserted mid-request -> imem_req=0 the next cycle, a late ack is ignored, and fetch restarts at RESET_VECTOR.
